bus_master: RTL and testbench
=============================

# bus_master

Master-side bus interface for the two-master shared RAM bus. It is one instance per master port (m0/m1). It accepts a burst transfer command from local logic and raises its request line toward the bus arbiter. Once granted, it drives address, write-enable and write data one word per cycle and returns read data to the local logic. It releases the bus when the burst completes. It tolerates grant loss mid-burst and the arbiter's default grant to m0.

## Interface
- ADDR_W, 8, bus address width; addresses wrap modulo 2^ADDR_W
- DATA_W, 32, bus data width
- LEN_W, 4, burst length field width; burst = cmd_len+1 words (1..16)
- clk  in  1  clock
- reset_n  in  1  asynchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  block idle, command accepted when cmd_valid & cmd_ready
- cmd_wr  in  1  1 = write burst, 0 = read burst
- cmd_addr  in  ADDR_W  start address
- cmd_len  in  LEN_W  words minus one
- wd_valid  in  1  write word available
- wd_ready  out  1  write word consumed this cycle when wd_valid & wd_ready
- wd_data  in  DATA_W  write word
- rd_valid  out  1  one-cycle pulse per returned read word, no backpressure
- rd_data  out  DATA_W  read word
- done  out  1  one-cycle pulse at burst completion
- m_req  out  1  bus request to arbiter
- m_grant  in  1  grant from arbiter
- m_wr  out  1  bus write strobe for this beat
- m_addr  out  ADDR_W  bus address
- m_dout  out  DATA_W  bus write data
- m_din  in  DATA_W  bus read data, valid the cycle after the read beat

## Operation
- States: IDLE, REQ, XFER, DRAIN.
- IDLE: cmd_ready=1. On accept, latch wr, addr, len into cur_addr, beats_left=len+1, and go to REQ.
- m_req = (state != IDLE).
- REQ: the arbiter's grant is registered, and it defaults to m0 with no request. Because of that, m_grant is ignored in the first REQ cycle and qualified from the second REQ cycle onward. When m_grant is qualified high, go to XFER.
- XFER beat condition: m_grant & beats_left != 0 & (read | wd_valid).
  - On a beat: cur_addr += 1 (wraps) and beats_left -= 1.
  - Write beat: m_wr=1, m_dout=wd_data, wd_ready=1.
  - Read beat: m_wr=0.
- No-beat cycle in XFER (grant lost or write data stalled): m_wr=0, wd_ready=0, cur_addr held, m_req held high.
- m_addr = cur_addr in XFER, 0 otherwise. m_dout = 0 when not a write beat.
- Read capture: one cycle after a read beat, register m_din into rd_data and assert rd_valid. A beat issued while granted always returns data, even if grant drops afterward.
- Last write beat: go to IDLE. done=1 in the first IDLE cycle.
- Last read beat: go to DRAIN for one cycle (m_req still 1), then go to IDLE. done and the final rd_valid both assert in the first IDLE cycle.
- cmd_valid outside IDLE is ignored.
- m_grant=0 in IDLE/REQ-first-cycle has no effect. m_grant=1 while in IDLE has no effect.

## Timing
- Reset values:
  - state IDLE, so m_req=0 and cmd_ready=1.
  - m_wr=0, m_addr=0, m_dout=0, wd_ready=0, rd_valid=0, rd_data=0, done=0, beats_left=0.
- Reset mid-burst: the bus is released immediately (async), no done pulse, and pending read data is discarded.
- Best-case latency with grant already held: accept at t; REQ at t+1, t+2; first beat at t+3.
- Write of N words, uninterrupted: beats t+3..t+2+N; done at t+3+N.
- Read of N words, uninterrupted: rd_valid at t+5..t+4+N; done at t+4+N.
- Throughput: one beat per granted cycle. Back-to-back commands: next accept is possible in the done cycle.

## Structure
- Shared package bus_pkg holds:
  - ADDR_W/DATA_W defaults, shared with the arbiter and RAM slave
  - the state enum (IDLE, REQ, XFER, DRAIN)
- Single module, no sub-module. The grant-qualify flag, beat counter and address counter are local registers.

## Test plan
- Write burst, cmd_addr=0x10, cmd_len=3, grant held, wd_valid constant: m_wr high 4 consecutive cycles on addresses 0x10..0x13 with matching m_dout; done 1 cycle after the last beat; m_req falls with done.
- Read burst, cmd_addr=0xFE, cmd_len=3, RAM model: addresses 0xFE, 0xFF, 0x00, 0x01; 4 rd_valid pulses with the model's data in order; done coincides with the 4th rd_valid.
- m_grant already 1 at REQ entry: no beat in the first REQ cycle. Then m_grant held 0 for 5 cycles: no m_wr/wd_ready, m_req stays 1; the first beat comes in the first qualified grant cycle.
- Write len=5, grant dropped for 3 cycles after 2 beats, plus wd_valid low for 1 cycle later: no beats in those cycles, address held; exactly 6 beats total, addresses contiguous.
- reset_n pulsed low during beat 2 of a 4-word read: m_req=0 immediately, no done, no further rd_valid; cmd_ready=1 after release; a new command completes normally.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared bus parameters and the master-side state encoding.
package bus_pkg;

    localparam int BUS_ADDR_W = 8;
    localparam int BUS_DATA_W = 32;
    localparam int BUS_LEN_W  = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        REQ   = 2'd1,
        XFER  = 2'd2,
        DRAIN = 2'd3
    } state_t;

endpackage

// File: rtl/bus_master.sv
// Burst master for the shared RAM bus: accept->first beat 3 cycles with grant held, one beat per granted cycle.
// Backpressure: cmd held off outside IDLE, write beats stall on wd_valid or grant loss; rd_valid has no backpressure.
module bus_master
    import bus_pkg::*;
#(
    parameter int ADDR_W = BUS_ADDR_W,
    parameter int DATA_W = BUS_DATA_W,
    parameter int LEN_W  = BUS_LEN_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_wr,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic              wd_valid,
    output logic              wd_ready,
    input  logic [DATA_W-1:0] wd_data,
    output logic              rd_valid,
    output logic [DATA_W-1:0] rd_data,
    output logic              done,
    output logic              m_req,
    input  logic              m_grant,
    output logic              m_wr,
    output logic [ADDR_W-1:0] m_addr,
    output logic [DATA_W-1:0] m_dout,
    input  logic [DATA_W-1:0] m_din
);

    state_t            state, state_nxt;
    logic              wr_q;
    logic              grant_ok;
    logic [ADDR_W-1:0] cur_addr;
    logic [LEN_W:0]    beats_left;
    logic              rd_beat_q;
    logic              beat;
    logic              last_beat;

    assign beat      = (state == XFER) && m_grant && (beats_left != '0) && (!wr_q || wd_valid);
    assign last_beat = beat && (beats_left == (LEN_W+1)'(1));
    assign m_req     = (state != IDLE);

    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        m_wr      = 1'b0;
        m_addr    = '0;
        m_dout    = '0;
        wd_ready  = 1'b0;
        case (state)
            IDLE: begin
                cmd_ready = 1'b1;
                if (cmd_valid) state_nxt = REQ;
            end
            REQ: begin
                // The arbiter's grant lags by a cycle and idles on m0, so the first REQ cycle is untrusted.
                if (grant_ok && m_grant) state_nxt = XFER;
            end
            XFER: begin
                m_addr = cur_addr;
                if (beat && wr_q) begin
                    m_wr     = 1'b1;
                    m_dout   = wd_data;
                    wd_ready = 1'b1;
                end
                if (last_beat) state_nxt = wr_q ? IDLE : DRAIN;
            end
            DRAIN:   state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state      <= IDLE;
            wr_q       <= 1'b0;
            grant_ok   <= 1'b0;
            cur_addr   <= '0;
            beats_left <= '0;
            rd_beat_q  <= 1'b0;
            rd_valid   <= 1'b0;
            rd_data    <= '0;
            done       <= 1'b0;
        end else begin
            state    <= state_nxt;
            grant_ok <= (state == REQ);
            if (state == IDLE && cmd_valid) begin
                wr_q       <= cmd_wr;
                cur_addr   <= cmd_addr;
                beats_left <= {1'b0, cmd_len} + (LEN_W+1)'(1);
            end else if (beat) begin
                cur_addr   <= cur_addr + ADDR_W'(1);
                beats_left <= beats_left - (LEN_W+1)'(1);
            end
            // Read data appears on m_din the cycle after its beat and is registered out one cycle later.
            rd_beat_q <= beat && !wr_q;
            rd_valid  <= rd_beat_q;
            if (rd_beat_q) rd_data <= m_din;
            done <= (last_beat && wr_q) || (state == DRAIN);
        end
    end

endmodule

// File: tb/tb_bus_master.sv
// Directed bench for bus_master with a small RAM slave model and hand-computed expectations.
module tb_bus_master;

    logic        clk = 1'b0;
    logic        reset_n;
    logic        cmd_valid, cmd_ready, cmd_wr;
    logic [7:0]  cmd_addr;
    logic [3:0]  cmd_len;
    logic        wd_valid, wd_ready;
    logic [31:0] wd_data;
    logic        rd_valid;
    logic [31:0] rd_data;
    logic        done, m_req, m_grant, m_wr;
    logic [7:0]  m_addr;
    logic [31:0] m_dout, m_din;

    bus_master dut (
        .clk(clk), .reset_n(reset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_wr(cmd_wr),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len),
        .wd_valid(wd_valid), .wd_ready(wd_ready), .wd_data(wd_data),
        .rd_valid(rd_valid), .rd_data(rd_data), .done(done),
        .m_req(m_req), .m_grant(m_grant), .m_wr(m_wr),
        .m_addr(m_addr), .m_dout(m_dout), .m_din(m_din)
    );

    always #5 clk = ~clk;

    // RAM slave: registered read of whatever address is on the bus.
    logic [31:0] mem [256];
    always @(posedge clk) begin
        if (m_wr) mem[m_addr] <= m_dout;
        m_din <= mem[m_addr];
    end

    int n_checks = 0;
    int n_fail   = 0;

    task automatic check_eq(input string tag, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    int          wcnt = 0;
    int          nbeats, first_beat, last_beat, done_cyc, first_rd, nrd;
    int          addr_err, wr_err, req_err;
    logic [7:0]  first_addr;
    logic        req_at_done;
    logic [31:0] rd_q [$];

    // Runs one command; cycle 0 is the accept cycle. Bit c of gmask/vmask drives m_grant/wd_valid in cycle c.
    task automatic do_cmd(input logic wr, input logic [7:0] addr, input logic [3:0] len,
                          input logic [63:0] gmask, input logic [63:0] vmask);
        nbeats = 0; first_beat = -1; last_beat = -1; done_cyc = -1; first_rd = -1; nrd = 0;
        addr_err = 0; wr_err = 0; req_err = 0; first_addr = 8'h00; req_at_done = 1'b1;
        rd_q.delete();
        for (int c = 0; c < 48 && done_cyc < 0; c++) begin
            @(posedge clk); #1;
            cmd_valid = (c == 0);
            cmd_wr    = wr;
            cmd_addr  = addr;
            cmd_len   = len;
            m_grant   = gmask[c];
            wd_valid  = wr & vmask[c];
            wd_data   = 32'hD000_0000 + wcnt;
            @(negedge clk);
            if (c == 0 && !cmd_ready) req_err++;
            if (c > 0 && !done && !m_req) req_err++;
            if (m_wr !== wd_ready) wr_err++;
            if (wd_ready) begin
                if (nbeats == 0) begin
                    first_beat = c;
                    first_addr = m_addr;
                end
                if (m_addr !== first_addr + 8'(nbeats)) addr_err++;
                if (m_dout !== wd_data) wr_err++;
                last_beat = c;
                nbeats++;
                wcnt++;
            end
            if (rd_valid) begin
                if (nrd == 0) first_rd = c;
                nrd++;
                rd_q.push_back(rd_data);
            end
            if (done) begin
                done_cyc    = c;
                req_at_done = m_req;
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        wd_valid  = 1'b0;
    endtask

    initial begin
        int rd_cnt, done_cnt;
        for (int i = 0; i < 256; i++) mem[i] = 32'h1000_0000 + i * 32'h0101;
        reset_n = 1'b0; cmd_valid = 1'b0; cmd_wr = 1'b0; cmd_addr = 8'h00; cmd_len = 4'h0;
        wd_valid = 1'b0; wd_data = 32'h0; m_grant = 1'b1;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check_eq("rst_m_req", m_req, 0);
        check_eq("rst_cmd_ready", cmd_ready, 1);
        check_eq("rst_m_wr", m_wr, 0);
        check_eq("rst_m_addr", m_addr, 0);
        check_eq("rst_m_dout", m_dout, 0);
        check_eq("rst_wd_ready", wd_ready, 0);
        check_eq("rst_rd_valid", rd_valid, 0);
        check_eq("rst_rd_data", rd_data, 0);
        check_eq("rst_done", done, 0);
        reset_n = 1'b1;

        // Write 4 words at 0x10 with grant held.
        do_cmd(1'b1, 8'h10, 4'd3, '1, '1);
        check_eq("w1_first_beat", first_beat, 3);
        check_eq("w1_nbeats", nbeats, 4);
        check_eq("w1_last_beat", last_beat, 6);
        check_eq("w1_first_addr", first_addr, 8'h10);
        check_eq("w1_addr_err", addr_err, 0);
        check_eq("w1_wr_err", wr_err, 0);
        check_eq("w1_done_cyc", done_cyc, 7);
        check_eq("w1_req_at_done", req_at_done, 0);
        check_eq("w1_req_err", req_err, 0);
        @(negedge clk);
        check_eq("w1_done_pulse", done, 0);
        check_eq("w1_mem13", mem[8'h13], 32'hD000_0003);

        // Read 4 words wrapping through 0xFF -> 0x00.
        do_cmd(1'b0, 8'hFE, 4'd3, '1, '0);
        check_eq("r2_nrd", nrd, 4);
        check_eq("r2_first_rd", first_rd, 5);
        check_eq("r2_done_cyc", done_cyc, 8);
        check_eq("r2_wr_err", wr_err, 0);
        check_eq("r2_req_err", req_err, 0);
        if (rd_q.size() == 4) begin
            check_eq("r2_d0", rd_q[0], 32'h1000_FEFE);
            check_eq("r2_d1", rd_q[1], 32'h1000_FFFF);
            check_eq("r2_d2", rd_q[2], 32'h1000_0000);
            check_eq("r2_d3", rd_q[3], 32'h1000_0101);
        end

        // Grant seen in first REQ cycle must be ignored, then withheld for 5 cycles.
        do_cmd(1'b1, 8'h40, 4'd1, 64'hFFFF_FFFF_FFFF_FF83, '1);
        check_eq("g3_first_beat", first_beat, 8);
        check_eq("g3_nbeats", nbeats, 2);
        check_eq("g3_done_cyc", done_cyc, 10);
        check_eq("g3_req_err", req_err, 0);
        check_eq("g3_wr_err", wr_err, 0);

        // 6-word write, grant lost cycles 5-7, write data stalled cycle 10.
        do_cmd(1'b1, 8'h80, 4'd5, 64'hFFFF_FFFF_FFFF_FF1F, 64'hFFFF_FFFF_FFFF_FBFF);
        check_eq("s4_nbeats", nbeats, 6);
        check_eq("s4_last_beat", last_beat, 12);
        check_eq("s4_first_addr", first_addr, 8'h80);
        check_eq("s4_addr_err", addr_err, 0);
        check_eq("s4_wr_err", wr_err, 0);
        check_eq("s4_done_cyc", done_cyc, 13);
        check_eq("s4_req_err", req_err, 0);

        // Reset asserted during beat 2 of a 4-word read.
        @(posedge clk); #1;
        cmd_valid = 1'b1; cmd_wr = 1'b0; cmd_addr = 8'h20; cmd_len = 4'd3; m_grant = 1'b1;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("x5_beat2_addr", m_addr, 8'h21);
        reset_n = 1'b0;
        #1;
        check_eq("x5_req_async", m_req, 0);
        check_eq("x5_addr_async", m_addr, 0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        rd_cnt = 0; done_cnt = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (rd_valid) rd_cnt++;
            if (done) done_cnt++;
        end
        check_eq("x5_no_rd_valid", rd_cnt, 0);
        check_eq("x5_no_done", done_cnt, 0);
        check_eq("x5_cmd_ready", cmd_ready, 1);
        do_cmd(1'b1, 8'h30, 4'd0, '1, '1);
        check_eq("x5_w_first_beat", first_beat, 3);
        check_eq("x5_w_done_cyc", done_cyc, 4);
        do_cmd(1'b0, 8'h30, 4'd0, '1, '0);
        check_eq("x5_r_nrd", nrd, 1);
        check_eq("x5_r_done_cyc", done_cyc, 5);
        check_eq("x5_r_first_rd", first_rd, 5);
        if (rd_q.size() == 1) check_eq("x5_r_data", rd_q[0], 32'hD000_000C);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
